regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the 8x8 two-read/one-write register file.
- Adds a second write port, optional write-to-read bypass, and a per-register pending scoreboard for pipeline hazard detection.
- Sits between decode (read/issue) and writeback (two retire lanes).
- Busy outputs feed the hazard/stall unit.

Parameters:
- DATA_W, 8: register width in bits.
- ADDR_W, 3: address width; depth = 2**ADDR_W.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, is never pending.
- BYPASS, 1: 1 = same-cycle write data forwarded to read ports and busy suppressed; 0 = reads see stored value only.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- ra1  in  ADDR_W  read address, port 1
- ra2  in  ADDR_W  read address, port 2
- rd1  out  DATA_W  read data, port 1 (combinational)
- rd2  out  DATA_W  read data, port 2 (combinational)
- we0  in  1  write enable, lane 0
- wa0  in  ADDR_W  write address, lane 0
- wd0  in  DATA_W  write data, lane 0
- we1  in  1  write enable, lane 1 (younger lane)
- wa1  in  ADDR_W  write address, lane 1
- wd1  in  DATA_W  write data, lane 1
- sb_set  in  1  issue strobe: mark sb_addr pending
- sb_addr  in  ADDR_W  destination of the issuing instruction
- flush  in  1  synchronous clear of all pending bits
- busy1  out  1  ra1 has an outstanding producer
- busy2  out  1  ra2 has an outstanding producer
- pend_cnt  out  ADDR_W+1  number of pending registers (registered)

Behaviour:
- Reset (rstn low, async): all registers = 0, all pending bits = 0, pend_cnt = 0. Outputs are combinational: rd* = 0 and busy* = 0 while reset is held.
- Writes commit on the rising edge.
- Both lanes writing the same address: lane 1 data wins.
- Write to address 0 is dropped when ZERO_REG = 1.
- Read, BYPASS = 0: rd = stored value, or 0 when addr = 0 and ZERO_REG = 1.
- Read, BYPASS = 1: priority for rdN is:
  1. 0, if addr = 0 and ZERO_REG = 1.
  2. wd1, if we1 and wa1 == raN.
  3. wd0, if we0 and wa0 == raN.
  4. Stored value.
- Pending bit p[a] is updated on each rising edge, first matching rule wins:
  1. flush = 1: every p <= 0; sb_set that cycle is ignored.
  2. sb_set and sb_addr == a (a != 0 when ZERO_REG = 1): p[a] <= 1. Set wins over a same-cycle write-clear (a new producer is in flight).
  3. (we0 and wa0 == a) or (we1 and wa1 == a): p[a] <= 0.
  4. Otherwise p[a] holds.
- busyN = p[raN].
  - BYPASS = 1: also forced 0 when a same-cycle write hits raN.
  - ZERO_REG = 1: forced 0 when raN = 0.
- pend_cnt = popcount of p after the edge update (one-cycle latency relative to the strobes). Maximum value is 2**ADDR_W (2**ADDR_W - 1 with ZERO_REG).
- A write to a non-pending register is legal: data is written, p is unchanged.
- sb_set to an already-pending register is legal: p stays 1 (write-after-write).

Test Plan:
- Reset then write: rstn pulse, then we0 = 1, wa0 = 3, wd0 = 8'hA5 -> next cycle ra1 = 3 gives rd1 = 8'hA5; rd2 at ra2 = 0 gives 0; pend_cnt = 0.
- Dual-write collision: we0 = we1 = 1, wa0 = wa1 = 5, wd0 = 8'h11, wd1 = 8'h22 -> same cycle (BYPASS = 1) rd1 = 8'h22 with ra1 = 5; after the edge the stored value = 8'h22.
- Zero register: we1 = 1, wa1 = 0, wd1 = 8'hFF, plus sb_set with sb_addr = 0 -> rd1 = 0 with ra1 = 0, busy1 = 0, pend_cnt unchanged.
- Scoreboard lifecycle: sb_set with sb_addr = 4 -> next cycle busy1 = 1 (ra1 = 4), pend_cnt = 1. Then we0 = 1, wa0 = 4, wd0 = 8'h3C -> same cycle busy1 = 0 and rd1 = 8'h3C (bypass); next cycle pend_cnt = 0.
- Set/clear race and flush:
  - sb_set 6 while we1 = 1, wa1 = 6 -> p[6] = 1 after the edge.
  - Then sb_set 2 while flush = 1 -> all p = 0, pend_cnt = 0.
- Async reset mid-operation: pend_cnt = 3 and reg 7 = 8'h77, then rstn low between edges -> immediately rd1 (ra1 = 7) = 0, busy* = 0, pend_cnt = 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two read ports, two write (retire) lanes,
// optional write-to-read bypass and a per-register pending scoreboard used by the
// hazard/stall unit. Lane 1 is the younger lane and wins same-address collisions.
module regfile_sb #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              flush,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [DEPTH-1:0]  set_vec, clr_vec;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic wr0_en, wr1_en;
    logic hit1, hit2;

    // Register 0 is hardwired to zero when ZERO_REG is set, so its writes are dropped.
    assign wr0_en = we0 && !(ZERO_REG && (wa0 == '0));
    assign wr1_en = we1 && !(ZERO_REG && (wa1 == '0));

    // A retiring write that targets a read address this cycle.
    assign hit1 = (we0 && (wa0 == ra1)) || (we1 && (wa1 == ra1));
    assign hit2 = (we0 && (wa0 == ra2)) || (we1 && (wa1 == ra2));

    // Storage: both lanes commit on the edge; lane 1 overrides lane 0 on a collision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr1_en && (wa1 == ADDR_W'(i))) begin
                    mem_q[i] <= wd1;
                end else if (wr0_en && (wa0 == ADDR_W'(i))) begin
                    mem_q[i] <= wd0;
                end
            end
        end
    end

    // Read port 1: stored value, optionally overridden by same-cycle writes (lane 1 first).
    always_comb begin
        rd1 = mem_q[ra1];
        if (BYPASS) begin
            if (we0 && (wa0 == ra1)) begin
                rd1 = wd0;
            end
            if (we1 && (wa1 == ra1)) begin
                rd1 = wd1;
            end
        end
        if (ZERO_REG && (ra1 == '0)) begin
            rd1 = '0;
        end
        // Bypassed write data must not leak out while reset is held.
        if (!rstn) begin
            rd1 = '0;
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rd2 = mem_q[ra2];
        if (BYPASS) begin
            if (we0 && (wa0 == ra2)) begin
                rd2 = wd0;
            end
            if (we1 && (wa1 == ra2)) begin
                rd2 = wd1;
            end
        end
        if (ZERO_REG && (ra2 == '0)) begin
            rd2 = '0;
        end
        if (!rstn) begin
            rd2 = '0;
        end
    end

    // Busy flags: pending producer, unless its result is being forwarded this cycle.
    always_comb begin
        busy1 = pend_q[ra1];
        busy2 = pend_q[ra2];
        if (BYPASS && hit1) begin
            busy1 = 1'b0;
        end
        if (BYPASS && hit2) begin
            busy2 = 1'b0;
        end
        if (ZERO_REG && (ra1 == '0)) begin
            busy1 = 1'b0;
        end
        if (ZERO_REG && (ra2 == '0)) begin
            busy2 = 1'b0;
        end
        if (!rstn) begin
            busy1 = 1'b0;
            busy2 = 1'b0;
        end
    end

    // Per-register set (issue) and clear (retire) requests.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sb_set && (sb_addr == ADDR_W'(i)) && !(ZERO_REG && (i == 0))) begin
                set_vec[i] = 1'b1;
            end
            if ((we0 && (wa0 == ADDR_W'(i))) || (we1 && (wa1 == ADDR_W'(i)))) begin
                clr_vec[i] = 1'b1;
            end
        end
    end

    // Scoreboard next state: flush beats everything, a new issue beats a retire-clear.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (set_vec[i]) begin
                    pend_d[i] = 1'b1;
                end else if (clr_vec[i]) begin
                    pend_d[i] = 1'b0;
                end
            end
        end
    end

    // Count tracks the post-update scoreboard, so it is registered alongside it.
    always_comb begin
        cnt_d = CNT_W'($countones(pend_d));
    end

    // Scoreboard and count registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (default parameters: 8x8, ZERO_REG=1, BYPASS=1).
// Directed scenarios followed by randomized traffic, all checked against an array model.
module tb_regfile_sb;

    logic       clk = 1'b0;
    logic       rstn;
    logic [2:0] ra1, ra2;
    logic [7:0] rd1, rd2;
    logic       we0, we1;
    logic [2:0] wa0, wa1;
    logic [7:0] wd0, wd1;
    logic       sb_set;
    logic [2:0] sb_addr;
    logic       flush;
    logic       busy1, busy2;
    logic [3:0] pend_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [7:0] mmem [8];
    bit         mp   [8];

    always #5 clk = ~clk;

    regfile_sb #(
        .DATA_W  (8),
        .ADDR_W  (3),
        .ZERO_REG(1'b1),
        .BYPASS  (1'b1)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2),
        .we0     (we0),
        .wa0     (wa0),
        .wd0     (wd0),
        .we1     (we1),
        .wa1     (wa1),
        .wd1     (wd1),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .flush   (flush),
        .busy1   (busy1),
        .busy2   (busy2),
        .pend_cnt(pend_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [2:0] ra);
        if (!rstn || ra == 3'd0) return 8'h00;
        if (we1 && wa1 == ra) return wd1;
        if (we0 && wa0 == ra) return wd0;
        return mmem[ra];
    endfunction

    function automatic logic exp_busy(input logic [2:0] ra);
        if (!rstn || ra == 3'd0) return 1'b0;
        if ((we0 && wa0 == ra) || (we1 && wa1 == ra)) return 1'b0;
        return mp[ra];
    endfunction

    function automatic logic [31:0] exp_cnt();
        int n = 0;
        foreach (mp[i]) n += int'(mp[i]);
        return n;
    endfunction

    task automatic model_reset();
        foreach (mmem[i]) mmem[i] = 8'h00;
        foreach (mp[i]) mp[i] = 1'b0;
    endtask

    // Apply the clock-edge rules: lane 0 then lane 1 (younger overwrites), clear then set.
    task automatic model_edge();
        if (we0 && wa0 != 3'd0) mmem[wa0] = wd0;
        if (we1 && wa1 != 3'd0) mmem[wa1] = wd1;
        if (flush) begin
            foreach (mp[i]) mp[i] = 1'b0;
        end else begin
            if (we0) mp[wa0] = 1'b0;
            if (we1) mp[wa1] = 1'b0;
            if (sb_set && sb_addr != 3'd0) mp[sb_addr] = 1'b1;
        end
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
        sb_set = 0; sb_addr = 0; flush = 0;
    endtask

    // Inputs are set at the falling edge; check combinational outputs, clock, check count.
    task automatic cycle(input string tag);
        #1;
        check({tag, "_rd1"}, 32'(rd1), 32'(exp_rd(ra1)));
        check({tag, "_rd2"}, 32'(rd2), 32'(exp_rd(ra2)));
        check({tag, "_busy1"}, 32'(busy1), 32'(exp_busy(ra1)));
        check({tag, "_busy2"}, 32'(busy2), 32'(exp_busy(ra2)));
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_cnt"}, 32'(pend_cnt), exp_cnt());
        @(negedge clk);
    endtask

    initial begin
        idle();
        ra1 = 3'd5; ra2 = 3'd0;
        rstn = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_rd1", 32'(rd1), 32'h0);
        check("reset_busy1", 32'(busy1), 32'h0);
        check("reset_cnt", 32'(pend_cnt), 32'h0);
        rstn = 1'b1;

        // Reset then write.
        we0 = 1; wa0 = 3'd3; wd0 = 8'hA5; ra1 = 3'd3; ra2 = 3'd0;
        cycle("wr3");
        idle();
        #1;
        check("wr3_rd1_const", 32'(rd1), 32'hA5);
        check("wr3_rd2_zero", 32'(rd2), 32'h0);
        check("wr3_cnt_const", 32'(pend_cnt), 32'h0);
        cycle("wr3_after");

        // Dual-write collision on address 5.
        we0 = 1; we1 = 1; wa0 = 3'd5; wa1 = 3'd5; wd0 = 8'h11; wd1 = 8'h22; ra1 = 3'd5;
        #1;
        check("coll_bypass_const", 32'(rd1), 32'h22);
        cycle("coll");
        idle();
        #1;
        check("coll_stored_const", 32'(rd1), 32'h22);
        cycle("coll_after");

        // Zero register ignores writes and scoreboard sets.
        we1 = 1; wa1 = 3'd0; wd1 = 8'hFF; sb_set = 1; sb_addr = 3'd0; ra1 = 3'd0;
        cycle("zero");
        idle();
        cycle("zero_after");

        // Scoreboard lifecycle on register 4.
        sb_set = 1; sb_addr = 3'd4; ra1 = 3'd4;
        cycle("sb4_set");
        idle();
        #1;
        check("sb4_busy_const", 32'(busy1), 32'h1);
        check("sb4_cnt_const", 32'(pend_cnt), 32'h1);
        we0 = 1; wa0 = 3'd4; wd0 = 8'h3C;
        #1;
        check("sb4_fwd_busy_const", 32'(busy1), 32'h0);
        check("sb4_fwd_rd_const", 32'(rd1), 32'h3C);
        cycle("sb4_clr");
        idle();
        check("sb4_cnt_zero_const", 32'(pend_cnt), 32'h0);

        // Set beats a same-cycle retire clear; flush beats a same-cycle set.
        sb_set = 1; sb_addr = 3'd6; we1 = 1; wa1 = 3'd6; wd1 = 8'h66; ra1 = 3'd6;
        cycle("race6");
        idle();
        #1;
        check("race6_busy_const", 32'(busy1), 32'h1);
        sb_set = 1; sb_addr = 3'd2; flush = 1; ra2 = 3'd2;
        cycle("flush");
        idle();
        check("flush_cnt_const", 32'(pend_cnt), 32'h0);

        // Async reset mid-operation.
        we0 = 1; wa0 = 3'd7; wd0 = 8'h77; sb_set = 1; sb_addr = 3'd1;
        cycle("pre_a");
        idle(); sb_set = 1; sb_addr = 3'd2;
        cycle("pre_b");
        idle(); sb_set = 1; sb_addr = 3'd3;
        cycle("pre_c");
        idle(); ra1 = 3'd7; ra2 = 3'd1;
        #2;
        check("pre_rd1_const", 32'(rd1), 32'h77);
        check("pre_busy2_const", 32'(busy2), 32'h1);
        check("pre_cnt_const", 32'(pend_cnt), 32'h3);
        rstn = 1'b0;
        we1 = 1; wa1 = 3'd7; wd1 = 8'h55;
        #1;
        check("arst_rd1", 32'(rd1), 32'h0);
        check("arst_busy1", 32'(busy1), 32'h0);
        check("arst_busy2", 32'(busy2), 32'h0);
        check("arst_cnt", 32'(pend_cnt), 32'h0);
        model_reset();
        @(negedge clk);
        idle();
        rstn = 1'b1;
        cycle("post_arst");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            we0     = ($urandom_range(0, 1) == 1);
            we1     = ($urandom_range(0, 2) == 0);
            wa0     = 3'($urandom_range(0, 7));
            wa1     = 3'($urandom_range(0, 7));
            wd0     = 8'($urandom);
            wd1     = 8'($urandom);
            sb_set  = ($urandom_range(0, 2) != 0);
            sb_addr = 3'($urandom_range(0, 7));
            flush   = ($urandom_range(0, 19) == 0);
            ra1     = 3'($urandom_range(0, 7));
            ra2     = ($urandom_range(0, 3) == 0) ? wa1 : 3'($urandom_range(0, 7));
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
